// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-memory controller: FSM states, access-size codes, lane mask.
// Pure declarations; no logic, no latency, no backpressure.
// Consumers import dmem_pkg::* for state_t, FUN3_* and byte_mask_t.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] FUN3_B  = 3'b000;
  localparam logic [2:0] FUN3_H  = 3'b001;
  localparam logic [2:0] FUN3_W  = 3'b010;
  localparam logic [2:0] FUN3_BU = 3'b100;
  localparam logic [2:0] FUN3_HU = 3'b101;

  typedef logic [3:0] byte_mask_t;

  // Bit 2 of fun3 only selects sign handling, so size comes from the low two bits.
  function automatic logic is_misaligned(input logic [2:0] fun3, input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    if (fun3[1:0] == FUN3_H[1:0]) w_mis = addr_lo[0];
    else if (fun3[1:0] == FUN3_W[1:0]) w_mis = (addr_lo != 2'b00);
    return w_mis;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Request/response bundle between the MEM-stage wrapper (master) and the data-memory controller (slave).
// Wires only; no latency.
// Backpressure is carried by stall: the master holds its request while stall is high.
interface dmem_access_ctrl_if;
  import dmem_pkg::*;

  logic        mem_en;
  logic        Load;
  logic [31:0] addr;
  logic [31:0] wdata;
  byte_mask_t  masking;
  logic [2:0]  fun3;
  logic [31:0] rdata;
  logic        data_valid;
  logic        stall;
  logic        fault;

  modport master (
    output mem_en, Load, addr, wdata, masking, fun3,
    input  rdata, data_valid, stall, fault
  );

  modport slave (
    input  mem_en, Load, addr, wdata, masking, fun3,
    output rdata, data_valid, stall, fault
  );

endinterface

// File: rtl/dmem_access_ctrl_bank.sv
// dmem_bank: single-port DEPTH_WORDS x 32 RAM with per-byte write enables; the array is never reset.
// Latency: write and read both take effect at the clock edge where i_en is high; read data is registered.
// No backpressure; o_rdata holds its value until the next read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_en,
  input  logic                           i_we,
  input  byte_mask_t                     i_be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  // Only the read register is reset so the word returned to the pipeline starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Multi-cycle data-memory controller: one load or byte-masked store per request; MISALIGN_TRAP_EN enables the fault trap.
// Latency: request seen at cycle 0 -> RAM access at cycle LATENCY -> data_valid at cycle LATENCY+1.
// Backpressure: stall is high from request acceptance through BUSY and low in DONE, so the pipeline advances once per access.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic               clk,
  input logic               rst_n,
  dmem_access_ctrl_if.slave bus
);

  localparam int                IDX_W    = $clog2(DEPTH_WORDS);
  localparam int                CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_is_store;
  logic             r_fault;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  byte_mask_t       r_mask;
  logic             w_req;
  logic             w_accept;
  logic             w_misalign;
  logic             w_ram_en;
  logic [31:0]      w_rdata;
  logic             w_unused_bits;

  assign w_req    = bus.mem_en | bus.Load;
  assign w_accept = (r_state == IDLE) && w_req;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = is_misaligned(bus.fun3, bus.addr[1:0]);
`else
  assign w_misalign = 1'b0;
`endif

  // Index bits above the array size are dropped, so out-of-range addresses wrap.
  assign w_unused_bits = ^{bus.addr[31:IDX_W+2], bus.addr[1:0], bus.fun3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_store <= 1'b0;
      r_fault    <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_mask     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_is_store <= bus.mem_en;
        r_fault    <= w_misalign;
        r_idx      <= bus.addr[IDX_W+1:2];
        r_wdata    <= bus.wdata;
        r_mask     <= bus.masking;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ram_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_misalign) begin
            w_state_nxt = DONE;
          end else begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (r_cnt == '0) begin
          w_ram_en    = 1'b1;
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign bus.stall      = w_accept || (r_state == BUSY);
  assign bus.data_valid = (r_state == DONE) && !r_is_store && !r_fault;

`ifdef MISALIGN_TRAP_EN
  assign bus.fault = (r_state == DONE) && r_fault;
`else
  assign bus.fault = 1'b0;
`endif

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_ram_en),
    .i_we   (r_is_store),
    .i_be   (r_mask),
    .i_idx  (r_idx),
    .i_wdata(r_wdata),
    .o_rdata(w_rdata)
  );

  assign bus.rdata = w_rdata;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed cases plus random traffic against a word-array reference model.
// A second instance built with LATENCY=1 covers the short-latency timing.
module tb_dmem_access_ctrl;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int NWIN  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_access_ctrl_if bus  ();
  dmem_access_ctrl_if bus1 ();

  dmem_access_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  dmem_access_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] rdata_m;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit misaligned(input logic [2:0] f, input logic [31:0] a);
    int sz;
    sz = (f[1:0] == 2'b00) ? 1 : (f[1:0] == 2'b01) ? 2 : 4;
    return (a % 32'(sz)) != 0;
  endfunction

  // Monitor: every data_valid pulse must match the oldest outstanding load.
  always @(negedge clk) begin
    if (rst_n && bus.data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected data_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("load rdata", bus.rdata, mon_exp);
      end
    end
  end

  task automatic access(input bit st, input bit ld, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] m, input logic [2:0] f);
    bit trap;
    bit exp_dv;
    int stall_n;
    int wi;
`ifdef MISALIGN_TRAP_EN
    trap = misaligned(f, a);
`else
    trap = 1'b0;
`endif
    exp_dv = !trap && ld && !st;
    wi     = widx(a);
    if (!trap) begin
      if (st) begin
        for (int i = 0; i < 4; i++) if (m[i]) mem_m[wi][8*i +: 8] = wd[8*i +: 8];
      end else if (ld) begin
        rdata_m = mem_m[wi];
        exp_q.push_back(rdata_m);
      end
    end
    @(negedge clk);
    bus.mem_en  = st;
    bus.Load    = ld;
    bus.addr    = a;
    bus.wdata   = wd;
    bus.masking = m;
    bus.fun3    = f;
    #1;
    stall_n = 0;
    while (bus.stall === 1'b1 && stall_n < 20) begin
      stall_n++;
      @(negedge clk);
    end
    check("stall cycles", 32'(stall_n), trap ? 32'd1 : 32'(LAT + 1));
    check("data_valid in done", 32'(bus.data_valid), 32'(exp_dv));
    check("fault in done", 32'(bus.fault), 32'(trap));
    bus.mem_en = 1'b0;
    bus.Load   = 1'b0;
    @(negedge clk);
    check("rdata held", bus.rdata, rdata_m);
    check("data_valid one cycle", 32'(bus.data_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          op;
    int          w;
    int          sel;
    int          stall_n;
    int          dv_cyc;
    int          dv_cnt;
    logic [31:0] a;
    logic [2:0]  f;

    bus.mem_en = 0; bus.Load = 0; bus.addr = 0; bus.wdata = 0; bus.masking = 0; bus.fun3 = 0;
    bus1.mem_en = 0; bus1.Load = 0; bus1.addr = 0; bus1.wdata = 0; bus1.masking = 0; bus1.fun3 = 0;
    rdata_m = 32'h0;
    repeat (3) @(negedge clk);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset data_valid", 32'(bus.data_valid), 32'd0);
    check("reset fault", 32'(bus.fault), 32'd0);
    check("reset rdata", bus.rdata, 32'h0);
    rst_n = 1'b1;

    // Word store then load, followed by a single-lane merge.
    access(1, 0, 32'h10, 32'hDEADBEEF, 4'b1111, FUN3_W);
    access(0, 1, 32'h10, 32'h0, 4'b1111, FUN3_W);
    access(1, 0, 32'h10, 32'h00AA0000, 4'b0100, FUN3_B);
    access(0, 1, 32'h10, 32'h0, 4'b1111, FUN3_BU);
    check("byte merge result", bus.rdata, 32'hDEAABEEF);

    // Store and load together: the store wins, no load response.
    access(1, 1, 32'h20, 32'h12345678, 4'b1111, FUN3_W);
    access(0, 1, 32'h20, 32'h0, 4'b1111, FUN3_W);
    check("store-wins word", bus.rdata, 32'h12345678);
    access(1, 0, 32'h20, 32'hFFFFFFFF, 4'b0000, FUN3_W);
    access(0, 1, 32'h20, 32'h0, 4'b1111, FUN3_W);
    access(1, 0, 32'hABCD1024, 32'hCAFEF00D, 4'b1111, FUN3_W);
    access(0, 1, 32'h24, 32'h0, 4'b1111, FUN3_W);

    // Misaligned word load: fault with the trap, otherwise a normal load.
    access(0, 1, 32'h42, 32'h0, 4'b1111, FUN3_W);
    access(0, 1, 32'h41, 32'h0, 4'b1111, FUN3_HU);

    // Reset asserted while a store is in BUSY must drop the write.
    access(1, 0, 32'h30, 32'h0, 4'b1111, FUN3_W);
    @(negedge clk);
    bus.mem_en = 1; bus.addr = 32'h30; bus.wdata = 32'hFFFFFFFF; bus.masking = 4'b1111; bus.fun3 = FUN3_W;
    @(negedge clk);
    check("busy stall before abort", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    bus.mem_en = 0;
    #1;
    check("stall after abort", 32'(bus.stall), 32'd0);
    check("rdata after abort", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rdata_m = 32'h0;
    access(0, 1, 32'h30, 32'h0, 4'b1111, FUN3_W);
    check("aborted store word", bus.rdata, 32'h0);

    // LATENCY=1 instance: load at cycle 0 -> data_valid at cycle 2, stall for cycles 0-1.
    @(negedge clk);
    bus1.mem_en = 1; bus1.addr = 32'h8; bus1.wdata = 32'h11223344; bus1.masking = 4'b1111; bus1.fun3 = FUN3_W;
    #1;
    stall_n = 0;
    while (bus1.stall === 1'b1 && stall_n < 20) begin
      stall_n++;
      @(negedge clk);
    end
    check("lat1 store stall cycles", 32'(stall_n), 32'd2);
    bus1.mem_en = 0;
    @(negedge clk);
    bus1.Load = 1;
    #1;
    stall_n = 0; dv_cyc = -1; dv_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus1.stall === 1'b1) stall_n++;
      if (bus1.data_valid === 1'b1) begin
        dv_cyc = c;
        dv_cnt++;
        check("lat1 rdata", bus1.rdata, 32'h11223344);
      end
      if (bus1.stall !== 1'b1) bus1.Load = 0;
      @(negedge clk);
    end
    check("lat1 stall cycles", 32'(stall_n), 32'd2);
    check("lat1 data_valid cycle", 32'(dv_cyc), 32'd2);
    check("lat1 data_valid pulses", 32'(dv_cnt), 32'd1);

    // Random traffic confined to a window of pre-written words, with random upper address bits.
    for (int i = 0; i < NWIN; i++) access(1, 0, 32'(i) << 2, $urandom(), 4'b1111, FUN3_W);
    for (int n = 0; n < 200; n++) begin
      op  = $urandom_range(0, 2);
      w   = $urandom_range(0, NWIN - 1);
      sel = $urandom_range(0, 4);
      case (sel)
        0:       f = FUN3_B;
        1:       f = FUN3_H;
        2:       f = FUN3_W;
        3:       f = FUN3_BU;
        default: f = FUN3_HU;
      endcase
      a = ($urandom() & 32'hFFFFF000) | (32'(w) << 2) | 32'($urandom_range(0, 3));
      access(op != 1, op != 0, a, $urandom(), 4'($urandom_range(0, 15)), f);
    end

    repeat (2) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
